// File: rtl/adder_share_arb.sv
// adder_share_arb: arbitrates NREQ requesters onto one shared adder through a two-stage
// operand/result pipeline. Define ADDER_SHARE_ARB_RR_EN for round-robin, else fixed priority.
module adder_share_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  input  logic [WIDTH-1:0]        add_y,
  output logic [NREQ-1:0]         resp_valid,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic [WIDTH-1:0]        resp_sum
);

  localparam int IDW = $clog2(NREQ);

  // Handshake: a request is accepted in the cycle req_valid[i] && req_ready[i];
  // the requester holds req_valid/req_a/req_b stable until then or withdraws it.

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   grant_id;
  logic             grant_valid;
  logic             s1_valid;
  logic [IDW-1:0]   s1_id;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Index arithmetic modulo NREQ, valid for non-power-of-two requester counts.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_add(ptr, k);
      if (!grant_valid && req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
    if (stall || !rst_n) begin
      grant_valid = 1'b0;
      grant_id    = '0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_valid) req_ready[grant_id] = 1'b1;
  end

`ifdef ADDER_SHARE_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= wrap_add(grant_id, 1);
    end
  end
`else
  assign ptr = '0;
`endif

  // Operand stage: the adder inputs only move on a grant, so idle cycles do not toggle them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      add_a    <= '0;
      add_b    <= '0;
    end else if (!stall) begin
      s1_valid <= grant_valid;
      if (grant_valid) begin
        s1_id <= grant_id;
        add_a <= a_arr[grant_id];
        add_b <= b_arr[grant_id];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_id    <= '0;
      resp_sum   <= '0;
    end else if (!stall) begin
      resp_sum   <= add_y;
      resp_id    <= s1_id;
      resp_valid <= s1_valid ? (NREQ'(1) << s1_id) : '0;
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed scenarios plus random traffic against an
// operation-level reference model (grant rule, in-flight list aged by unstalled cycles).
module tb_adder_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stall = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W-1:0]      add_y;
  logic [NREQ-1:0]   resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_sum;

  assign add_y = add_a + add_b;

  adder_share_arb #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_y(add_y),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  int           m_ptr;
  logic [W-1:0] m_last_a, m_last_b;
  int           m_last_id;
  logic [W-1:0] m_resp_sum;
  int           m_resp_id;
  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           age_q[$];
  int           m_gnt;

  logic [NREQ-1:0] last_ready, last_resp_valid;
  logic [W-1:0]    last_resp_sum;
  logic [IDW-1:0]  last_resp_id;

  task automatic model_reset();
    m_ptr = 0; m_last_a = '0; m_last_b = '0; m_last_id = 0;
    m_resp_sum = '0; m_resp_id = 0;
    exp_q.delete(); id_q.delete(); age_q.delete();
  endtask

  function automatic logic [W-1:0] slice_of(input logic [NREQ*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  function automatic int model_pick();
    int i;
    if (!rst_n || stall) return -1;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // One clock: check outputs at negedge, then advance the model across the posedge.
  task automatic cycle();
    logic [NREQ-1:0] exp_ready, exp_rv;
    @(negedge clk);
    m_gnt = model_pick();
    exp_ready = '0;
    if (m_gnt >= 0) exp_ready[m_gnt] = 1'b1;
    exp_rv = '0;
    if (age_q.size() > 0 && age_q[0] == 2) exp_rv[id_q[0]] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    check("add_a", add_a, m_last_a);
    check("add_b", add_b, m_last_b);
    check("resp_valid", resp_valid, exp_rv);
    check("resp_id", resp_id, m_resp_id);
    if (exp_rv != '0) check("resp_sum", resp_sum, exp_q[0]);
    else              check("resp_sum_idle", resp_sum, m_resp_sum);
    last_ready = req_ready; last_resp_valid = resp_valid;
    last_resp_sum = resp_sum; last_resp_id = resp_id;
    @(posedge clk);
    if (rst_n && !stall) begin
      foreach (age_q[i]) age_q[i]++;
      if (age_q.size() > 0 && age_q[0] > 2) begin
        void'(exp_q.pop_front()); void'(id_q.pop_front()); void'(age_q.pop_front());
      end
      m_resp_sum = m_last_a + m_last_b;
      m_resp_id  = m_last_id;
      if (m_gnt >= 0) begin
        m_last_a  = slice_of(req_a, m_gnt);
        m_last_b  = slice_of(req_b, m_gnt);
        m_last_id = m_gnt;
        exp_q.push_back(m_last_a + m_last_b);
        id_q.push_back(m_gnt);
        age_q.push_back(1);
`ifdef ADDER_SHARE_ARB_RR_EN
        m_ptr = (m_gnt + 1) % NREQ;
`endif
      end
    end
    #1;
  endtask

  // stimulus
  initial begin
    logic [NREQ-1:0] e;
    logic [W-1:0]    s_exp;
    bit              pend [NREQ];
    bit              found;
    int              cnt;

    model_reset();
    rst_n = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = $urandom;
      req_b[i*W +: W] = $urandom;
    end
    repeat (3) begin
      cycle();
      check("rst_ready", last_ready, 0);
    end
    rst_n = 1'b1;

    // round-robin with all requesters active
    for (int k = 0; k < 8; k++) begin
      cycle();
      e = '0;
`ifdef ADDER_SHARE_ARB_RR_EN
      e[k % NREQ] = 1'b1;
`else
      e[0] = 1'b1;
`endif
      check("rr_grant", last_ready, e);
    end
    req_valid = '0;
    repeat (3) cycle();

    // single request on index 2
    req_valid = 4'b0100;
    req_a[2*W +: W] = 32'h0000_0005;
    req_b[2*W +: W] = 32'h0000_0007;
    cycle();
    check("single_ready", last_ready, 4'b0100);
    req_valid = '0;
    cycle();
    cycle();
    check("single_resp_valid", last_resp_valid, 4'b0100);
    check("single_resp_id", last_resp_id, 2);
    check("single_resp_sum", last_resp_sum, 32'h0000_000C);

    // carry-out wraps
    req_valid = 4'b0010;
    req_a[1*W +: W] = 32'hFFFF_FFFF;
    req_b[1*W +: W] = 32'h0000_0002;
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    check("wrap_resp_valid", last_resp_valid, 4'b0010);
    check("wrap_resp_sum", last_resp_sum, 32'h0000_0001);

    // stall while an operation is in flight
    req_valid = 4'b0001;
    req_a[0*W +: W] = $urandom;
    req_b[0*W +: W] = $urandom;
    s_exp = req_a[0*W +: W] + req_b[0*W +: W];
    cycle();
    check("stall_grant", last_ready, 4'b0001);
    req_valid = 4'b1000;
    stall = 1'b1;
    repeat (3) begin
      cycle();
      check("stall_no_grant", last_ready, 0);
      check("stall_no_resp", last_resp_valid, 0);
    end
    stall = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      cycle();
      if (last_ready[3]) req_valid = '0;
      if (last_resp_valid[0]) begin
        found = 1'b1;
        check("stall_resp_sum", last_resp_sum, s_exp);
      end
    end
    check("stall_resp_seen", found, 1'b1);
    req_valid = '0;
    repeat (3) cycle();

    // reset one cycle after a grant discards the operation
    req_valid = 4'b0100;
    req_a[2*W +: W] = $urandom;
    cycle();
    req_valid = '0;
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      cycle();
      if (last_resp_valid != '0) cnt++;
    end
    check("rst_mid_no_resp", cnt, 0);
    req_valid = '1;
    cycle();
    check("rst_mid_ptr0", last_ready, 4'b0001);
    req_valid = '0;
    cycle();

    // random traffic with stalls, withdrawals and occasional reset
    foreach (pend[i]) pend[i] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
        foreach (pend[i]) pend[i] = 1'b0;
        req_valid = '0;
        cycle();
        rst_n = 1'b1;
      end
      stall = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && $urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          req_a[i*W +: W] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
          req_b[i*W +: W] = $urandom;
        end
        req_valid[i] = pend[i];
      end
      cycle();
      if (m_gnt >= 0) pend[m_gnt] = 1'b0;
    end
    stall = 1'b0;
    req_valid = '0;
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
